mem_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one single-port memory (en/wr, synchronous write, combinational read, `WIDTH` x `DEPTH`) between `NREQ` requesters.
- Each requester has a valid/ready command channel and a valid/ready response channel.
- The arbiter holds one outstanding transaction at a time, drives the memory port from registers, and returns registered read data or a write acknowledge.
- It sits between client engines and the shared memory instance.

---
 rtl/mem_arb_pkg.sv | 25 ++
 rtl/mem_arbiter_rr_arbiter.sv | 46 ++++
 rtl/mem_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_arbiter.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the memory arbiter: FSM states and the registered command.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package mem_arb_pkg;

  // Command fields are sized for the largest supported configuration; the
  // arbiter uses only the low AW/WIDTH/owner bits and ties the rest to zero.
  localparam int MAX_WIDTH = 64;
  localparam int MAX_AW    = 16;
  localparam int OWNER_W   = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  typedef struct packed {
    logic                 wr;
    logic [MAX_AW-1:0]    addr;
    logic [MAX_WIDTH-1:0] wdata;
    logic [OWNER_W-1:0]   owner;
  } cmd_t;

endpackage

// File: rtl/mem_arbiter_rr_arbiter.sv
// Combinational one-hot grant: round-robin search from ptr, or fixed lowest-index
// priority when MEM_ARB_FIXED_PRIO_EN is defined (ptr is then ignored).
// Latency: zero cycles. Backpressure: none, pure function of req/ptr.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

`ifdef MEM_ARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  // Lowest set index wins: scan high to low so the last hit is the lowest.
  always_comb begin
    gnt = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        gnt    = '0;
        gnt[i] = 1'b1;
      end
    end
  end
`else
  logic [PW-1:0] idx;
  logic          found;

  // First requester found when walking ptr, ptr+1, ... modulo N.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = PW'((int'(ptr) + k) % N);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between NREQ requesters, one transaction at a time.
// Latency: accept at edge N, memory access in cycle N+1, response valid from N+2.
// Backpressure: req_ready only in IDLE; response held until owner's rsp_ready.
// Build option: MEM_ARB_FIXED_PRIO_EN selects fixed lowest-index priority.
module mem_arbiter import mem_arb_pkg::*; #(
  parameter int  WIDTH = 8,
  parameter int  DEPTH = 64,
  parameter int  NREQ  = 2,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ-1:0]       req_wr,
  input  logic [NREQ*AW-1:0]    req_addr,
  input  logic [NREQ*WIDTH-1:0] req_wdata,
  output logic [NREQ-1:0]       rsp_valid,
  input  logic [NREQ-1:0]       rsp_ready,
  output logic [WIDTH-1:0]      rsp_rdata,
  output logic                  mem_en,
  output logic                  mem_wr,
  output logic [AW-1:0]         mem_addr,
  output logic [WIDTH-1:0]      mem_wdata,
  input  logic [WIDTH-1:0]      mem_rdata
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t           state_q;
  cmd_t             cmd_q;
  logic [WIDTH-1:0] rdata_q;
  logic [NREQ-1:0]  gnt;
  logic [PW-1:0]    gnt_idx;
  logic [PW-1:0]    rr_ptr;
  logic [PW-1:0]    owner;
  logic             sel_wr;
  logic [AW-1:0]    sel_addr;
  logic [WIDTH-1:0] sel_wdata;
  logic             accept;

  assign owner  = cmd_q.owner[PW-1:0];
  assign accept = (state_q == IDLE) && (|gnt);

`ifdef MEM_ARB_FIXED_PRIO_EN
  assign rr_ptr = '0;
`else
  logic [PW-1:0] rr_q;
  assign rr_ptr = rr_q;

  // Round-robin pointer moves to the requester after the one just accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q <= '0;
    end else if (accept) begin
      rr_q <= (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + PW'(1);
    end
  end
`endif

  rr_arbiter #(.N(NREQ), .PW(PW)) u_arb (
    .req (req_valid),
    .ptr (rr_ptr),
    .gnt (gnt)
  );

  // Select the granted requester's command fields from the one-hot grant.
  always_comb begin
    gnt_idx   = '0;
    sel_wr    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        gnt_idx   = PW'(i);
        sel_wr    = req_wr[i];
        sel_addr  = req_addr[i*AW +: AW];
        sel_wdata = req_wdata[i*WIDTH +: WIDTH];
      end
    end
  end

  // Sequencer: accept one command, access memory for one cycle, hold response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            cmd_q.wr    <= sel_wr;
            cmd_q.addr  <= MAX_AW'(sel_addr);
            cmd_q.wdata <= MAX_WIDTH'(sel_wdata);
            cmd_q.owner <= OWNER_W'(gnt_idx);
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          // Write commits in memory at this same edge; its response carries 0.
          rdata_q <= cmd_q.wr ? '0 : mem_rdata;
          state_q <= RESP;
        end
        RESP: begin
          if (rsp_ready[owner]) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Response valid is one-hot on the owner; reset suppresses it in the same cycle.
  always_comb begin
    rsp_valid = '0;
    if (state_q == RESP && !rst) begin
      rsp_valid[owner] = 1'b1;
    end
  end

  assign req_ready = (state_q == IDLE && !rst) ? gnt : '0;
  assign rsp_rdata = rdata_q;

  // Enable is gated by rst so a reset cycle never performs the access.
  assign mem_en    = (state_q == ISSUE) && !rst;
  assign mem_wr    = mem_en && cmd_q.wr;
  assign mem_addr  = cmd_q.addr[AW-1:0];
  assign mem_wdata = cmd_q.wdata[WIDTH-1:0];

  logic unused_cmd_hi;
  assign unused_cmd_hi = ^{cmd_q.addr >> AW, cmd_q.wdata >> WIDTH, cmd_q.owner >> PW};

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
// Holds a behavioural memory on the mem_* port.
module tb_mem_arbiter;

  localparam int WIDTH = 8;
  localparam int DEPTH = 64;
  localparam int NREQ  = 2;
  localparam int AW    = 6;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       req_wr = '0;
  logic [NREQ*AW-1:0]    req_addr = '0;
  logic [NREQ*WIDTH-1:0] req_wdata = '0;
  logic [NREQ-1:0]       rsp_valid;
  logic [NREQ-1:0]       rsp_ready = '0;
  logic [WIDTH-1:0]      rsp_rdata;
  logic                  mem_en;
  logic                  mem_wr;
  logic [AW-1:0]         mem_addr;
  logic [WIDTH-1:0]      mem_wdata;
  logic [WIDTH-1:0]      mem_rdata;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  mem_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NREQ(NREQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .mem_en    (mem_en),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [WIDTH-1:0] init_val(int i);
    if (i == 1) return 8'h11;
    if (i == 2) return 8'h22;
    return WIDTH'(i * 7 + 3);
  endfunction

  // Behavioural single-port memory: synchronous write, combinational read.
  logic [WIDTH-1:0] mem [DEPTH];
  logic             preload_done = 1'b0;
  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (!preload_done) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= init_val(i);
    end else if (mem_en && mem_wr) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit bit_at(logic [NREQ-1:0] v, int i);
    logic [NREQ-1:0] t;
    t = v >> i;
    return t[0];
  endfunction

  // Arbitration rule: first valid requester searching from rr (or from 0 in fixed mode).
  function automatic int model_grant(logic [NREQ-1:0] v, int rr);
    int start;
    start = rr;
`ifdef MEM_ARB_FIXED_PRIO_EN
    start = 0;
`endif
    for (int k = 0; k < NREQ; k++) begin
      if (bit_at(v, (start + k) % NREQ)) return (start + k) % NREQ;
    end
    return -1;
  endfunction

  // Reference model: one outstanding transaction with an age since acceptance.
  logic [WIDTH-1:0] ref_mem [DEPTH];
  bit               m_busy  = 1'b0;
  int               m_age   = 0;
  int               m_owner = 0;
  int               m_rr    = 0;
  bit               m_wr    = 1'b0;
  logic [AW-1:0]    m_maddr = '0;
  logic [WIDTH-1:0] m_mwdata = '0;
  logic [WIDTH-1:0] m_rdata = '0;

  int               acc_q[$];
  int               acc_cyc[$];
  logic [WIDTH-1:0] rsp_q[$];

  initial begin : scoreboard
    int              g;
    logic [NREQ-1:0] e_rdy, e_vld;
    bit              e_en, e_wr;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_val(i);
    forever begin
      @(negedge clk);
      g = model_grant(req_valid, m_rr);
      if (rst) begin
        e_rdy = '0; e_vld = '0; e_en = 1'b0; e_wr = 1'b0;
      end else begin
        e_rdy = (!m_busy && g >= 0) ? NREQ'(1) << g : '0;
        e_en  = m_busy && (m_age == 1);
        e_wr  = e_en && m_wr;
        e_vld = (m_busy && m_age == 2) ? NREQ'(1) << m_owner : '0;
      end
      chk("m_req_ready", 32'(req_ready), 32'(e_rdy));
      chk("m_rsp_valid", 32'(rsp_valid), 32'(e_vld));
      chk("m_rsp_rdata", 32'(rsp_rdata), 32'(m_rdata));
      chk("m_mem_en",    32'(mem_en),    32'(e_en));
      chk("m_mem_wr",    32'(mem_wr),    32'(e_wr));
      chk("m_mem_addr",  32'(mem_addr),  32'(m_maddr));
      chk("m_mem_wdata", 32'(mem_wdata), 32'(m_mwdata));
      chk("m_ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);

      // Handshake log for directed scenarios.
      if (!rst && (req_valid & req_ready) != '0) begin
        for (int i = 0; i < NREQ; i++) if (bit_at(req_valid & req_ready, i)) acc_q.push_back(i);
        acc_cyc.push_back(cyc);
      end
      if (!rst && (rsp_valid & rsp_ready) != '0) rsp_q.push_back(rsp_rdata);

      // Advance model across the coming edge.
      if (rst) begin
        m_busy = 1'b0; m_rr = 0; m_rdata = '0; m_maddr = '0; m_mwdata = '0;
      end else if (!m_busy) begin
        if (g >= 0) begin
          m_busy   = 1'b1;
          m_age    = 1;
          m_owner  = g;
          m_wr     = bit_at(req_wr, g);
          m_maddr  = AW'(req_addr >> (g * AW));
          m_mwdata = WIDTH'(req_wdata >> (g * WIDTH));
          m_rr     = (g + 1) % NREQ;
        end
      end else if (m_age == 1) begin
        if (m_wr) begin
          ref_mem[m_maddr] = m_mwdata;
          m_rdata = '0;
        end else begin
          m_rdata = ref_mem[m_maddr];
        end
        m_age = 2;
      end else if (bit_at(rsp_ready, m_owner)) begin
        m_busy = 1'b0;
      end
    end
  end

  task automatic set_cmd(input int p, input bit wr, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    req_wr[p]                 = wr;
    req_addr[p*AW +: AW]      = a;
    req_wdata[p*WIDTH +: WIDTH] = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Waits for port p to be accepted; returns just after the accepting edge.
  task automatic wait_acc(input int p);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (bit_at(req_valid & req_ready, p)) begin
        ok = 1'b1;
        break;
      end
    end
    chk($sformatf("accept_p%0d", p), 32'(ok), 32'd1);
    @(posedge clk);
    #1;
  endtask

  // Single transaction on port p with rsp_ready[p] high; checks latency pattern.
  task automatic txn(input int p, input bit wr, input logic [AW-1:0] a,
                     input logic [WIDTH-1:0] d, output logic [WIDTH-1:0] rd);
    set_cmd(p, wr, a, d);
    req_valid[p] = 1'b1;
    wait_acc(p);
    req_valid[p] = 1'b0;
    @(negedge clk);
    chk("issue_mem_en", 32'(mem_en), 32'd1);
    chk("issue_mem_wr", 32'(mem_wr), 32'(wr));
    chk("issue_mem_addr", 32'(mem_addr), 32'(a));
    chk("issue_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk("resp_mem_en", 32'(mem_en), 32'd0);
    chk("resp_rsp_valid", 32'(rsp_valid), 32'(NREQ'(1) << p));
    rd = rsp_rdata;
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [WIDTH-1:0] rd;
    int               n;

    // Reset, with requests asserted to show they are ignored.
    req_valid = '1;
    @(posedge clk);
    #1 preload_done = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    chk("rst_mem_en",    32'(mem_en),    32'd0);
    chk("rst_mem_addr",  32'(mem_addr),  32'd0);
    @(posedge clk);
    #1 req_valid = '0;
    rst = 1'b0;

    // Write then read on port 0.
    rsp_ready = '1;
    txn(0, 1'b1, 6'd5, 8'hA5, rd);
    chk("wr_rsp_rdata", 32'(rd), 32'd0);
    txn(0, 1'b0, 6'd5, 8'h00, rd);
    chk("rd_rsp_rdata", 32'(rd), 32'hA5);

    // Contention or fixed priority with both ports valid.
    do_reset();
    acc_q.delete(); acc_cyc.delete(); rsp_q.delete();
    set_cmd(0, 1'b0, 6'd1, 8'h00);
    set_cmd(1, 1'b0, 6'd2, 8'h00);
    rsp_ready = '1;
    req_valid = 2'b11;
`ifdef MEM_ARB_FIXED_PRIO_EN
    n = 0;
    while (acc_q.size() < 4 && n < 60) begin @(posedge clk); n++; end
    #1;
    for (int k = 0; k < 4; k++)
      chk($sformatf("fixed_grant%0d", k), 32'(k < acc_q.size() ? acc_q[k] : -1), 32'd0);
    req_valid[0] = 1'b0;
    n = 0;
    while (acc_q.size() < 5 && n < 60) begin @(posedge clk); n++; end
    #1 req_valid = '0;
    chk("fixed_grant_after_drop", 32'(acc_q.size() >= 5 ? acc_q[4] : -1), 32'd1);
`else
    n = 0;
    while (rsp_q.size() < 4 && n < 60) begin @(posedge clk); n++; end
    #1 req_valid = '0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("cont_grant%0d", k), 32'(k < acc_q.size() ? acc_q[k] : -1), 32'(k % 2));
      chk($sformatf("cont_rdata%0d", k), 32'(k < rsp_q.size() ? rsp_q[k] : 8'hFF),
          (k % 2 == 0) ? 32'h11 : 32'h22);
    end
    chk("cont_spacing", 32'(acc_cyc.size() >= 2 ? acc_cyc[1] - acc_cyc[0] : -1), 32'd3);
`endif
    repeat (6) @(posedge clk);
    #1;

    // Response backpressure on port 1.
    do_reset();
    rsp_ready = 2'b01;
    set_cmd(1, 1'b0, 6'd2, 8'h00);
    req_valid[1] = 1'b1;
    wait_acc(1);
    req_valid[1] = 1'b0;
    set_cmd(0, 1'b0, 6'd1, 8'h00);
    req_valid[0] = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_rsp_valid", 32'(rsp_valid), 32'b10);
      chk("bp_rsp_rdata", 32'(rsp_rdata), 32'h22);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clk);
    #1 rsp_ready = 2'b11;
    @(negedge clk);
    chk("bp_last_valid", 32'(rsp_valid), 32'b10);
    chk("bp_last_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("bp_after_ready", 32'(req_ready), 32'b01);
    @(posedge clk);
    #1 req_valid = '0;
    repeat (4) @(posedge clk);
    #1;

    // Reset during RESP.
    do_reset();
    rsp_ready = '0;
    set_cmd(0, 1'b0, 6'd1, 8'h00);
    req_valid[0] = 1'b1;
    wait_acc(0);
    set_cmd(1, 1'b0, 6'd2, 8'h00);
    req_valid[1] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("mr_resp_valid", 32'(rsp_valid), 32'b01);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("mr_rstcyc_valid", 32'(rsp_valid), 32'd0);
    chk("mr_rstcyc_ready", 32'(req_ready), 32'd0);
    chk("mr_rstcyc_en",    32'(mem_en),    32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mr_post_valid", 32'(rsp_valid), 32'd0);
    chk("mr_post_rdata", 32'(rsp_rdata), 32'd0);
    chk("mr_post_en",    32'(mem_en),    32'd0);
    chk("mr_post_addr",  32'(mem_addr),  32'd0);
    chk("mr_post_ready", 32'(req_ready), 32'b01);
    rsp_ready = '1;
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    wait_acc(1);
    req_valid[1] = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Read-after-write to the same address across ports.
    do_reset();
    rsp_ready = '1;
    set_cmd(0, 1'b1, 6'd63, 8'h3C);
    set_cmd(1, 1'b0, 6'd63, 8'h00);
    req_valid = 2'b11;
    wait_acc(0);
    req_valid[0] = 1'b0;
    wait_acc(1);
    req_valid[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("raw_rsp_valid", 32'(rsp_valid), 32'b10);
    chk("raw_rsp_rdata", 32'(rsp_rdata), 32'h3C);
    @(posedge clk);
    #1;

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(0, 299) == 0);
      req_valid = NREQ'($urandom);
      req_wr    = NREQ'($urandom);
      for (int p = 0; p < NREQ; p++) begin
        req_addr[p*AW +: AW]        = AW'($urandom_range(0, 3) == 0 ? $urandom : $urandom_range(60, 63));
        req_wdata[p*WIDTH +: WIDTH] = WIDTH'($urandom);
      end
      rsp_ready = ($urandom_range(0, 3) == 0) ? NREQ'($urandom) : '1;
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    req_valid = '0;
    rsp_ready = '1;
    repeat (6) @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
